axi_aw_w_packetizer: RTL
========================

Name: axi_aw_w_packetizer

Overview:
- Injection end of the cut-through AXI-Stream network: converts one AXI4 write request (AW plus W burst) into an AXI-Stream packet.
- Packet layout: one header flit, then len+1 data flits, TLAST on the final flit.
- Output drives a router input queue; a pause input, fed from that queue's half_full, holds off new packets at packet boundaries only.

Parameters:
- DATA_WIDTH, 32, AXI W and AXI-Stream TDATA width; must be at least ADDR_WIDTH+11 (elaboration-time assertion).
- ADDR_WIDTH, 16, AW address width.
- ID_WIDTH, 4, AWID and TID width.
- DEST_WIDTH, 4, TDEST width; taken from aw_addr[ADDR_WIDTH-1 -: DEST_WIDTH].

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- aw_valid  in  1  AW valid
- aw_ready  out  1  AW ready
- aw_id  in  ID_WIDTH  AWID
- aw_addr  in  ADDR_WIDTH  AWADDR
- aw_len  in  8  AWLEN (beats-1)
- aw_size  in  3  AWSIZE
- w_valid  in  1  W valid
- w_ready  out  1  W ready
- w_data  in  DATA_WIDTH  WDATA
- w_strb  in  DATA_WIDTH/8  WSTRB
- w_last  in  1  WLAST
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tdata  out  DATA_WIDTH  flit payload
- m_tstrb  out  DATA_WIDTH/8  byte strobes
- m_tlast  out  1  last flit of packet
- m_tid  out  ID_WIDTH  latched AWID
- m_tdest  out  DEST_WIDTH  destination node
- m_tuser  out  1  1 = header flit, 0 = data flit
- pause  in  1  block start of new packet
- len_error  out  1  one-cycle pulse on WLAST/AWLEN mismatch

Behaviour:
- Reset (async assert, sync release):
  - All m_* outputs, len_error, aw_ready and w_ready are 0.
  - State is IDLE; beat counter is 0.
- Output register:
  - All m_* signals are registered.
  - load_ok = !m_tvalid || m_tready.
  - A loaded flit holds stable while m_tvalid && !m_tready.
  - m_tvalid clears when the flit is taken and no new flit loads in the same cycle.
- FSM has states IDLE and DATA.
- IDLE:
  - aw_ready = !pause && load_ok; w_ready = 0.
  - On AW handshake, load the header flit:
    - tdata[ADDR_WIDTH-1:0] = aw_addr; next 8 bits = aw_len; next 3 bits = aw_size; upper bits 0.
    - tstrb all ones, tuser 1, tlast 0.
  - On AW handshake, also latch aw_id into m_tid, the address slice into m_tdest, and aw_len into the counter; go to DATA.
- DATA:
  - w_ready = load_ok; aw_ready = 0.
  - On W handshake, load the data flit: tdata = w_data, tstrb = w_strb, tuser 0, tlast = (counter==0).
  - Counter decrements on each beat. When a beat is taken with counter==0, go to IDLE.
  - pause is ignored in DATA; a started packet always completes.
- Latency and throughput:
  - Accepted beat to m_tvalid: 1 cycle.
  - Sustained throughput: 1 flit/cycle.
  - Back-to-back packets: header of packet k+1 may load in the cycle after the last data flit of packet k loads.
- Length rule:
  - m_tlast comes from the counter only and never from w_last.
  - len_error pulses for one cycle on any W beat where w_last != (counter==0).
  - Flit count is unchanged by a mismatch: exactly aw_len+1 data flits are always emitted.
- Packet size: aw_len = N gives N+2 flits. aw_len = 255 is legal; the counter is 8-bit and no wrap occurs.
- W data presented while in IDLE is not accepted.
- Reset mid-packet: the partial packet is dropped and the output returns to reset values. The downstream queue must tolerate a truncated packet (no TLAST).

Decomposition:
- Package axi_noc_pkg:
  - Header field offsets/widths (HDR_ADDR_LSB, HDR_LEN_LSB, HDR_SIZE_LSB).
  - FLIT_HEADER/FLIT_DATA tuser constants.
  - Packed header struct typedef.
  - Shared with the future depacketizer on the ejection side.
- One natural sub-module: axis_out_reg, the single-stage registered output with load_ok logic, reusable by the depacketizer.

Test Plan:
- Single beat: aw_addr=0x3A10, aw_len=0, aw_id=5, one W beat 0xDEADBEEF with last=1, tready=1 -> flit 1 tuser=1, tdata=0x00003A10, tdest=3, tid=5; flit 2 tdata=0xDEADBEEF, tlast=1, tuser=0; len_error never asserted.
- Backpressure: aw_len=3, data 1..4, tready toggling 1010 -> exactly 5 flits, in order, each stable while stalled, tlast only on data 4.
- Length mismatch: aw_len=2, w_last=1 on beat 0 -> len_error pulses in that beat's cycle; still 3 data flits, tlast on third.
- Pause: pause=1 with aw_valid=1 -> aw_ready=0 and no flits. Raise pause mid-packet -> remaining data flits still flow; next AW blocked until pause=0.
- Back-to-back: two packets (len 0 and 1) with continuous valid and tready=1 -> 5 flits in 5 consecutive cycles, no bubble.
- Reset mid-packet: rst_n=0 after 2 of 4 data flits -> m_tvalid=0 immediately; after release, a new AW produces a clean header.

Source files
------------

// File: rtl/axi_noc_pkg.sv
// Shared definitions for the AXI-Stream NoC injection/ejection ends:
// header flit layout, flit-type tags and the packetizer FSM state type.
package axi_noc_pkg;

    localparam int NOC_ADDR_WIDTH = 16;
    localparam int HDR_ADDR_LSB   = 0;
    localparam int HDR_LEN_WIDTH  = 8;
    localparam int HDR_SIZE_WIDTH = 3;
    localparam int HDR_LEN_LSB    = HDR_ADDR_LSB + NOC_ADDR_WIDTH;
    localparam int HDR_SIZE_LSB   = HDR_LEN_LSB + HDR_LEN_WIDTH;

    localparam logic FLIT_HEADER = 1'b1;
    localparam logic FLIT_DATA   = 1'b0;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_DATA = 1'b1
    } pkt_state_t;

    // Header word for the default address width; fields from the LSB up.
    typedef struct packed {
        logic [HDR_SIZE_WIDTH-1:0] size;
        logic [HDR_LEN_WIDTH-1:0]  len;
        logic [NOC_ADDR_WIDTH-1:0] addr;
    } noc_hdr_t;

    // Field offsets for an arbitrary address width.
    function automatic int hdr_len_lsb(input int addr_width);
        return HDR_ADDR_LSB + addr_width;
    endfunction

    function automatic int hdr_size_lsb(input int addr_width);
        return hdr_len_lsb(addr_width) + HDR_LEN_WIDTH;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage registered AXI-Stream source: captures one flit when load is
// asserted and the stage can accept, holds it stable until the sink takes it.
module axis_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [DATA_WIDTH-1:0]   ld_tdata,
    input  logic [DATA_WIDTH/8-1:0] ld_tstrb,
    input  logic                    ld_tlast,
    input  logic [ID_WIDTH-1:0]     ld_tid,
    input  logic [DEST_WIDTH-1:0]   ld_tdest,
    input  logic                    ld_tuser,
    output logic                    load_ok,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tstrb,
    output logic                    m_tlast,
    output logic [ID_WIDTH-1:0]     m_tid,
    output logic [DEST_WIDTH-1:0]   m_tdest,
    output logic                    m_tuser
);

    logic                    tvalid_reg;
    logic [DATA_WIDTH-1:0]   tdata_reg;
    logic [DATA_WIDTH/8-1:0] tstrb_reg;
    logic                    tlast_reg;
    logic [ID_WIDTH-1:0]     tid_reg;
    logic [DEST_WIDTH-1:0]   tdest_reg;
    logic                    tuser_reg;

    assign load_ok = !tvalid_reg || m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid_reg <= 1'b0;
            tdata_reg  <= '0;
            tstrb_reg  <= '0;
            tlast_reg  <= 1'b0;
            tid_reg    <= '0;
            tdest_reg  <= '0;
            tuser_reg  <= 1'b0;
        end else if (load && load_ok) begin
            tvalid_reg <= 1'b1;
            tdata_reg  <= ld_tdata;
            tstrb_reg  <= ld_tstrb;
            tlast_reg  <= ld_tlast;
            tid_reg    <= ld_tid;
            tdest_reg  <= ld_tdest;
            tuser_reg  <= ld_tuser;
        end else if (m_tready) begin
            // Payload is left in place; only valid drops once the flit is taken.
            tvalid_reg <= 1'b0;
        end
    end

    assign m_tvalid = tvalid_reg;
    assign m_tdata  = tdata_reg;
    assign m_tstrb  = tstrb_reg;
    assign m_tlast  = tlast_reg;
    assign m_tid    = tid_reg;
    assign m_tdest  = tdest_reg;
    assign m_tuser  = tuser_reg;

endmodule

// File: rtl/axi_aw_w_packetizer.sv
// NoC injection end: turns one AXI4 AW + W burst into a header flit followed
// by aw_len+1 data flits; TLAST is derived from AWLEN, never from WLAST.
module axi_aw_w_packetizer
    import axi_noc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic [ID_WIDTH-1:0]       aw_id,
    input  logic [ADDR_WIDTH-1:0]     aw_addr,
    input  logic [HDR_LEN_WIDTH-1:0]  aw_len,
    input  logic [HDR_SIZE_WIDTH-1:0] aw_size,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic [DATA_WIDTH/8-1:0]   w_strb,
    input  logic                      w_last,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tstrb,
    output logic                      m_tlast,
    output logic [ID_WIDTH-1:0]       m_tid,
    output logic [DEST_WIDTH-1:0]     m_tdest,
    output logic                      m_tuser,
    input  logic                      pause,
    output logic                      len_error
);

    localparam int LEN_LSB  = hdr_len_lsb(ADDR_WIDTH);
    localparam int SIZE_LSB = hdr_size_lsb(ADDR_WIDTH);

    if (DATA_WIDTH < ADDR_WIDTH + HDR_LEN_WIDTH + HDR_SIZE_WIDTH) begin : g_width_check
        $error("axi_aw_w_packetizer: DATA_WIDTH must be at least ADDR_WIDTH+11");
    end

    pkt_state_t               state_reg, state_next;
    logic [HDR_LEN_WIDTH-1:0] count_reg, count_next;
    logic [ID_WIDTH-1:0]      id_reg;
    logic [DEST_WIDTH-1:0]    dest_reg;
    logic                     run_reg;

    logic                     load;
    logic                     load_ok;
    logic [DATA_WIDTH-1:0]    hdr_word;
    logic [DATA_WIDTH-1:0]    ld_tdata;
    logic [DATA_WIDTH/8-1:0]  ld_tstrb;
    logic                     ld_tlast;
    logic [ID_WIDTH-1:0]      ld_tid;
    logic [DEST_WIDTH-1:0]    ld_tdest;
    logic                     ld_tuser;
    logic                     aw_fire;
    logic                     w_fire;
    logic                     last_beat;

    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_ADDR_LSB +: ADDR_WIDTH]   = aw_addr;
        hdr_word[LEN_LSB +: HDR_LEN_WIDTH]     = aw_len;
        hdr_word[SIZE_LSB +: HDR_SIZE_WIDTH]   = aw_size;
    end

    assign last_beat = (count_reg == '0);
    assign aw_fire   = aw_valid && aw_ready;
    assign w_fire    = w_valid && w_ready;
    assign len_error = w_fire && (w_last != last_beat);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        load       = 1'b0;
        ld_tdata   = hdr_word;
        ld_tstrb   = '1;
        ld_tlast   = 1'b0;
        ld_tuser   = FLIT_HEADER;
        ld_tid     = aw_id;
        ld_tdest   = aw_addr[ADDR_WIDTH-1 -: DEST_WIDTH];
        case (state_reg)
            PKT_IDLE: begin
                // pause is only honoured here, so packets never split.
                aw_ready = run_reg && !pause && load_ok;
                if (aw_valid && aw_ready) begin
                    load       = 1'b1;
                    count_next = aw_len;
                    state_next = PKT_DATA;
                end
            end
            PKT_DATA: begin
                w_ready  = load_ok;
                ld_tdata = w_data;
                ld_tstrb = w_strb;
                ld_tlast = last_beat;
                ld_tuser = FLIT_DATA;
                ld_tid   = id_reg;
                ld_tdest = dest_reg;
                if (w_valid && w_ready) begin
                    load = 1'b1;
                    if (last_beat) begin
                        state_next = PKT_IDLE;
                    end else begin
                        count_next = count_reg - 1'b1;
                    end
                end
            end
            default: state_next = PKT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= PKT_IDLE;
            count_reg <= '0;
            id_reg    <= '0;
            dest_reg  <= '0;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            run_reg   <= 1'b1;
            if (aw_fire) begin
                id_reg   <= aw_id;
                dest_reg <= aw_addr[ADDR_WIDTH-1 -: DEST_WIDTH];
            end
        end
    end

    axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .DEST_WIDTH (DEST_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .ld_tdata (ld_tdata),
        .ld_tstrb (ld_tstrb),
        .ld_tlast (ld_tlast),
        .ld_tid   (ld_tid),
        .ld_tdest (ld_tdest),
        .ld_tuser (ld_tuser),
        .load_ok  (load_ok),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tstrb  (m_tstrb),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .m_tdest  (m_tdest),
        .m_tuser  (m_tuser)
    );

endmodule
